// File: rtl/ps2_host_ctrl.sv
// PS/2 host controller: filtered RX framing into a show-ahead FIFO, host-to-device TX with ACK check.
// Latency: raw ps2_c fall to internal edge is 2+FILT_LEN cycles; good byte visible on rx_valid one cycle after the stop edge.
// Backpressure: FIFO full drops new bytes with an rx_ovf pulse; tx_write is ignored while tx_busy is high.
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   ps2_c, ps2_d    open-drain PS/2 clock/data (driven 0 or released to Z)
//   tx_data/tx_write/tx_busy/tx_done/tx_err   host-to-device byte transmit
//   rx_data/rx_valid/rx_read/rx_count         receive FIFO (show-ahead head)
//   rx_perr/rx_ferr/rx_ovf                    receive error pulses
module ps2_host_ctrl #(
    parameter int FILT_LEN    = 8,
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 100000,
    parameter int DEPTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    inout  wire                      ps2_c,
    inout  wire                      ps2_d,
    input  logic [7:0]               tx_data,
    input  logic                     tx_write,
    output logic                     tx_busy,
    output logic                     tx_done,
    output logic                     tx_err,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_read,
    output logic                     rx_perr,
    output logic                     rx_ferr,
    output logic                     rx_ovf,
    output logic [$clog2(DEPTH):0]   rx_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    // ------------------------------------------------------------------
    // Pin drivers: open-drain, only ever pull low
    // ------------------------------------------------------------------
    logic c_oe;
    logic d_oe;

    assign ps2_c = c_oe ? 1'b0 : 1'bz;
    assign ps2_d = d_oe ? 1'b0 : 1'bz;

    // ------------------------------------------------------------------
    // Synchronisers and clock glitch filter
    // ------------------------------------------------------------------
    logic                c_s1, c_s2, d_s1, d_s2;
    logic [FILT_LEN-1:0] filt_sr;
    logic                c_filt;
    logic                fall_edge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_s1    <= 1'b1;
            c_s2    <= 1'b1;
            d_s1    <= 1'b1;
            d_s2    <= 1'b1;
            filt_sr <= '1;
            c_filt  <= 1'b1;
        end else begin
            c_s1    <= ps2_c;
            c_s2    <= c_s1;
            d_s1    <= ps2_d;
            d_s2    <= d_s1;
            filt_sr <= {filt_sr[FILT_LEN-2:0], c_s2};
            if (&filt_sr)
                c_filt <= 1'b1;
            else if (~|filt_sr)
                c_filt <= 1'b0;
        end
    end

    // High for exactly the one cycle in which c_filt is about to drop.
    assign fall_edge = c_filt & ~|filt_sr;

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_INHIBIT, TX_REQ, TX_BITS, TX_ACK, TX_WAITIDLE
    } tx_state_t;

    tx_state_t       tx_state;
    logic [8:0]      tx_sh;      // {parity, data}, shifted out LSB first
    logic [3:0]      tx_bitn;
    logic [TW-1:0]   tx_tmr;
    logic [IW-1:0]   inh_cnt;
    logic            tx_start;
    logic            tx_to;

    assign tx_start = (tx_state == TX_IDLE) && tx_write;
    // INHIBIT is host-timed, so the watchdog only covers device-clocked states.
    assign tx_to    = (tx_state inside {TX_REQ, TX_BITS, TX_ACK, TX_WAITIDLE})
                      && !fall_edge && (tx_tmr == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_sh    <= '0;
            tx_bitn  <= '0;
            tx_tmr   <= '0;
            inh_cnt  <= '0;
            c_oe     <= 1'b0;
            d_oe     <= 1'b0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            if (fall_edge)
                tx_tmr <= '0;
            else
                tx_tmr <= tx_tmr + 1'b1;

            if (tx_to) begin
                tx_err   <= 1'b1;
                c_oe     <= 1'b0;
                d_oe     <= 1'b0;
                tx_busy  <= 1'b0;
                tx_state <= TX_IDLE;
            end else begin
                case (tx_state)
                    TX_IDLE: begin
                        tx_tmr <= '0;
                        if (tx_write) begin
                            tx_sh    <= {~^tx_data, tx_data};
                            inh_cnt  <= '0;
                            c_oe     <= 1'b1;
                            tx_busy  <= 1'b1;
                            tx_state <= TX_INHIBIT;
                        end
                    end
                    TX_INHIBIT: begin
                        // Timer held at zero so REQ starts a fresh watchdog window.
                        tx_tmr  <= '0;
                        inh_cnt <= inh_cnt + 1'b1;
                        if (inh_cnt == INH_LAST) begin
                            c_oe     <= 1'b0;
                            d_oe     <= 1'b1;   // start bit
                            tx_state <= TX_REQ;
                        end
                    end
                    TX_REQ: begin
                        // First device clock: put bit0 on the line.
                        if (fall_edge) begin
                            d_oe     <= ~tx_sh[0];
                            tx_sh    <= {1'b0, tx_sh[8:1]};
                            tx_bitn  <= 4'd1;
                            tx_state <= TX_BITS;
                        end
                    end
                    TX_BITS: begin
                        if (fall_edge) begin
                            if (tx_bitn == 4'd9) begin
                                d_oe     <= 1'b0;   // stop bit: release
                                tx_state <= TX_ACK;
                            end else begin
                                d_oe    <= ~tx_sh[0];
                                tx_sh   <= {1'b0, tx_sh[8:1]};
                                tx_bitn <= tx_bitn + 1'b1;
                            end
                        end
                    end
                    TX_ACK: begin
                        if (fall_edge) begin
                            if (!d_s2) begin
                                tx_state <= TX_WAITIDLE;
                            end else begin
                                tx_err   <= 1'b1;
                                c_oe     <= 1'b0;
                                d_oe     <= 1'b0;
                                tx_busy  <= 1'b0;
                                tx_state <= TX_IDLE;
                            end
                        end
                    end
                    TX_WAITIDLE: begin
                        if (c_filt && d_s2) begin
                            tx_done  <= 1'b1;
                            tx_busy  <= 1'b0;
                            tx_state <= TX_IDLE;
                        end
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    rx_state_t       rx_state;
    logic [7:0]      rx_sh;
    logic [2:0]      rx_bitn;
    logic [TW-1:0]   rx_tmr;
    logic            rx_par_ok;
    logic            rx_hold;
    logic            rx_to;
    logic            rx_push;

    // A transmit owns the bus: any partial receive is dropped without error.
    assign rx_hold = tx_start | tx_busy;
    assign rx_to   = (rx_state != RX_IDLE) && !fall_edge && (rx_tmr == TO_LAST);
    assign rx_push = !rx_hold && (rx_state == RX_STOP) && fall_edge && d_s2 && rx_par_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state  <= RX_IDLE;
            rx_sh     <= '0;
            rx_bitn   <= '0;
            rx_tmr    <= '0;
            rx_par_ok <= 1'b0;
            rx_perr   <= 1'b0;
            rx_ferr   <= 1'b0;
        end else begin
            rx_perr <= 1'b0;
            rx_ferr <= 1'b0;
            if (fall_edge)
                rx_tmr <= '0;
            else
                rx_tmr <= rx_tmr + 1'b1;

            if (rx_hold) begin
                rx_state <= RX_IDLE;
                rx_tmr   <= '0;
            end else if (rx_to) begin
                rx_ferr  <= 1'b1;
                rx_state <= RX_IDLE;
            end else begin
                case (rx_state)
                    RX_IDLE: begin
                        rx_tmr <= '0;
                        // An edge with data high is noise, not a start bit.
                        if (fall_edge && !d_s2) begin
                            rx_bitn  <= '0;
                            rx_state <= RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (fall_edge) begin
                            rx_sh   <= {d_s2, rx_sh[7:1]};
                            rx_bitn <= rx_bitn + 1'b1;
                            if (rx_bitn == 3'd7)
                                rx_state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        if (fall_edge) begin
                            rx_par_ok <= ^{d_s2, rx_sh};
                            rx_state  <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        if (fall_edge) begin
                            rx_state <= RX_IDLE;
                            if (!d_s2)
                                rx_ferr <= 1'b1;
                            else if (!rx_par_ok)
                                rx_perr <= 1'b1;
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO (show-ahead)
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          push_ok;

    assign full     = (rx_count == FULL_CNT);
    assign pop      = rx_read && (rx_count != '0);
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign push_ok  = rx_push && (!full || pop);
    assign rx_valid = (rx_count != '0);
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= rx_sh;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
            rx_ovf   <= 1'b0;
        end else begin
            rx_ovf <= rx_push && !push_ok;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

endmodule
